// File: rtl/guess_session_pkg.sv
// guess_session_pkg: shared types for the guess session controller
package guess_session_pkg;
  localparam int SEQ_LEN_DEF = 8;
  typedef enum logic [2:0] {IDLE, ARMED, SHIFT, EVAL, UNLOCKED, LOCKOUT} state_e;
  typedef enum logic {GRANT_SW, GRANT_PS} grant_e;
endpackage

// File: rtl/guess_session_if.sv
// guess_session_if: guess shift handshake between session controller and detector
interface guess_session_if;
  logic       secret_ready;
  logic [3:0] match_count;
  logic       guess_valid;
  logic       guess_bit;
  logic       clear_guess;
  modport master (input secret_ready, match_count, output guess_valid, guess_bit, clear_guess);
  modport slave (output secret_ready, match_count, input guess_valid, guess_bit, clear_guess);
endinterface

// File: rtl/guess_session_ctrl_req_capture.sv
// req_capture: rising-edge capture of one requester's guess bit with sticky overrun
module req_capture (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic bit_in,
  input  logic accept,
  input  logic take,
  input  logic flush,
  output logic pending,
  output logic cap_bit,
  output logic overrun
);
  logic req_q, pending_q, pending_d, bit_q, bit_d, ovr_q, ovr_d, rise;
  always_comb begin
    rise = req & ~req_q;
    pending_d = pending_q & ~take & ~flush;
    bit_d = bit_q;
    ovr_d = ovr_q;
    if (rise && accept && !pending_q && !flush) begin
      pending_d = 1'b1;
      bit_d = bit_in;
    end else if (rise) begin
      ovr_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= 1'b0;
      pending_q <= 1'b0;
      bit_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      req_q <= req;
      pending_q <= pending_d;
      bit_q <= bit_d;
      ovr_q <= ovr_d;
    end
  end
  assign pending = pending_q;
  assign cap_bit = bit_q;
  assign overrun = ovr_q;
endmodule

// File: rtl/guess_session_ctrl.sv
// guess_session_ctrl: arbitrates PS/switch guess bits into the detector and runs attempt/lockout session
module guess_session_ctrl
  import guess_session_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int FLASH_CYCLES   = 125000000,
  parameter int LOCKOUT_CYCLES = 625000000,
  parameter int SEQ_LEN        = SEQ_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  guess_session_if.master        det,
  input  logic                   ps_req,
  input  logic                   ps_bit,
  input  logic                   sw_req,
  input  logic                   sw_bit,
  input  logic                   relock,
  output logic                   grant_ps,
  output logic                   flash_red,
  output logic                   unlocked,
  output logic                   locked_out,
  output logic [3:0]             fail_count,
  output logic [3:0]             bit_count,
  output logic                   overrun
);
  localparam int FW = $clog2(FLASH_CYCLES) + 1;
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
  state_e state_q, state_d;
  grant_e last_q, last_d;
  logic [3:0] fail_q, fail_d, bits_q, bits_d, prev_q, prev_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [LW-1:0] lock_q, lock_d;
  logic clear_q, clear_d;
  logic ps_pend, sw_pend, ps_cap, sw_cap, ps_ovr, sw_ovr;
  logic take_ps, take_sw, accept, flush;
  req_capture u_ps (.clk(clk), .reset_n(reset_n), .req(ps_req), .bit_in(ps_bit), .accept(accept),
                    .take(take_ps), .flush(flush), .pending(ps_pend), .cap_bit(ps_cap), .overrun(ps_ovr));
  req_capture u_sw (.clk(clk), .reset_n(reset_n), .req(sw_req), .bit_in(sw_bit), .accept(accept),
                    .take(take_sw), .flush(flush), .pending(sw_pend), .cap_bit(sw_cap), .overrun(sw_ovr));
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    fail_d = fail_q;
    bits_d = bits_q;
    prev_d = prev_q;
    flash_d = (flash_q != '0) ? flash_q - FW'(1) : '0;
    lock_d = lock_q;
    clear_d = 1'b0;
    take_ps = 1'b0;
    take_sw = 1'b0;
    flush = 1'b0;
    accept = det.secret_ready & (state_q inside {ARMED, SHIFT, EVAL});
    case (state_q)
      IDLE: state_d = det.secret_ready ? ARMED : IDLE;
      ARMED: if (ps_pend || sw_pend) begin
        // round robin on a tie: the requester that did not win last time goes first
        take_ps = ps_pend & (~sw_pend | (last_q == GRANT_SW));
        take_sw = sw_pend & ~take_ps;
        last_d = take_ps ? GRANT_PS : GRANT_SW;
        state_d = SHIFT;
      end
      SHIFT: state_d = EVAL;
      EVAL: if (det.match_count == 4'(SEQ_LEN)) begin
        state_d = UNLOCKED;
        flash_d = '0;
      end else begin
        flash_d = (det.match_count <= prev_q) ? FW'(FLASH_CYCLES) : flash_d;
        prev_d = det.match_count;
        bits_d = bits_q + 4'd1;
        state_d = ARMED;
        if (bits_q == 4'(SEQ_LEN - 1)) begin
          fail_d = (fail_q == 4'hf) ? fail_q : fail_q + 4'd1;
          clear_d = 1'b1;
          bits_d = '0;
          prev_d = '0;
          if (fail_d == 4'(MAX_FAILS)) begin
            state_d = LOCKOUT;
            lock_d = LW'(LOCKOUT_CYCLES);
          end
        end
      end
      UNLOCKED: if (relock) begin
        state_d = ARMED;
        clear_d = 1'b1;
        fail_d = '0;
        bits_d = '0;
        prev_d = '0;
      end
      LOCKOUT: begin
        lock_d = lock_q - LW'(1);
        if (lock_q <= LW'(1)) begin
          state_d = ARMED;
          fail_d = '0;
          lock_d = '0;
          flush = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // losing the secret wipes the session; the detector clears itself
    if (!det.secret_ready) begin
      state_d = IDLE;
      last_d = last_q;
      fail_d = '0;
      bits_d = '0;
      prev_d = '0;
      flash_d = '0;
      lock_d = '0;
      clear_d = 1'b0;
      take_ps = 1'b0;
      take_sw = 1'b0;
      flush = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= GRANT_SW;
      fail_q <= '0;
      bits_q <= '0;
      prev_q <= '0;
      flash_q <= '0;
      lock_q <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      fail_q <= fail_d;
      bits_q <= bits_d;
      prev_q <= prev_d;
      flash_q <= flash_d;
      lock_q <= lock_d;
      clear_q <= clear_d;
    end
  end
  assign det.guess_valid = state_q == SHIFT;
  assign det.guess_bit = (state_q == SHIFT) & ((last_q == GRANT_PS) ? ps_cap : sw_cap);
  assign det.clear_guess = clear_q;
  assign grant_ps = (state_q == SHIFT) & (last_q == GRANT_PS);
  assign flash_red = (flash_q != '0) | (state_q == LOCKOUT);
  assign unlocked = state_q == UNLOCKED;
  assign locked_out = state_q == LOCKOUT;
  assign fail_count = fail_q;
  assign bit_count = bits_q;
  assign overrun = ps_ovr | sw_ovr;
endmodule

// File: tb/tb_guess_session_ctrl.sv
// tb_guess_session_ctrl: directed scenario bench for guess_session_ctrl
module tb_guess_session_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic ps_req = 1'b0, ps_bit = 1'b0, sw_req = 1'b0, sw_bit = 1'b0, relock = 1'b0;
  logic grant_ps, flash_red, unlocked, locked_out, overrun;
  logic [3:0] fail_count, bit_count;
  logic [15:0] outs;
  int n_cmp = 0, n_bad = 0;
  guess_session_if bus();
  guess_session_ctrl #(.MAX_FAILS(2), .FLASH_CYCLES(4), .LOCKOUT_CYCLES(10), .SEQ_LEN(8)) dut (
    .clk(clk), .reset_n(reset_n), .det(bus), .ps_req(ps_req), .ps_bit(ps_bit),
    .sw_req(sw_req), .sw_bit(sw_bit), .relock(relock), .grant_ps(grant_ps),
    .flash_red(flash_red), .unlocked(unlocked), .locked_out(locked_out),
    .fail_count(fail_count), .bit_count(bit_count), .overrun(overrun));
  always #5 clk = ~clk;
  assign outs = {bus.guess_valid, bus.guess_bit, bus.clear_guess, grant_ps, flash_red,
                 unlocked, locked_out, fail_count, bit_count, overrun};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic restart;
    bus.secret_ready = 1'b0;
    tick();
    bus.secret_ready = 1'b1;
    tick();
  endtask

  task automatic run_bit(input logic b, input logic [3:0] mc);
    bus.match_count = mc;
    ps_bit = b;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.secret_ready = 1'b0;
    bus.match_count = 4'd0;
    tick();
    tick();
    n_cmp++;
    if (outs !== 16'h0000) begin n_bad++; $display("FAIL reset_outs: got %h want 0000", outs); end
    reset_n = 1'b1;
    bus.secret_ready = 1'b1;
    tick();
  endtask

  task automatic test_round_robin;
    for (int p = 0; p < 2; p++) begin
      ps_bit = 1'b1; sw_bit = 1'b0; ps_req = 1'b1; sw_req = 1'b1;
      tick();
      ps_req = 1'b0; sw_req = 1'b0;
      tick();
      n_cmp++;
      if ({bus.guess_valid, bus.guess_bit, grant_ps} !== 3'b111) begin
        n_bad++; $display("FAIL rr_first[%0d]: got %b want 111", p, {bus.guess_valid, bus.guess_bit, grant_ps});
      end
      tick();
      tick();
      n_cmp++;
      if (bus.guess_valid !== 1'b0) begin n_bad++; $display("FAIL rr_gap[%0d]: got %b want 0", p, bus.guess_valid); end
      tick();
      n_cmp++;
      if ({bus.guess_valid, bus.guess_bit, grant_ps} !== 3'b100) begin
        n_bad++; $display("FAIL rr_second[%0d]: got %b want 100", p, {bus.guess_valid, bus.guess_bit, grant_ps});
      end
      tick();
      tick();
    end
  endtask

  task automatic test_latency;
    restart();
    bus.match_count = 4'd0;
    ps_bit = 1'b1;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    n_cmp++;
    if (bus.guess_valid !== 1'b0) begin n_bad++; $display("FAIL lat_c1_valid: got %b want 0", bus.guess_valid); end
    tick();
    n_cmp++;
    if ({bus.guess_valid, bus.guess_bit, grant_ps} !== 3'b111) begin
      n_bad++; $display("FAIL lat_c2_shift: got %b want 111", {bus.guess_valid, bus.guess_bit, grant_ps});
    end
    tick();
    n_cmp++;
    if ({bus.guess_valid, bit_count} !== 5'd0) begin
      n_bad++; $display("FAIL lat_c3_eval: got %b want 00000", {bus.guess_valid, bit_count});
    end
    tick();
    n_cmp++;
    if (bit_count !== 4'd1) begin n_bad++; $display("FAIL lat_c4_bits: got %0d want 1", bit_count); end
  endtask

  task automatic test_flash;
    logic [3:0] seq [3];
    seq = '{4'd1, 4'd2, 4'd3};
    restart();
    for (int i = 0; i < 3; i++) begin
      run_bit(1'b0, seq[i]);
      n_cmp++;
      if (flash_red !== 1'b0) begin n_bad++; $display("FAIL flash_rising[%0d]: got %b want 0", i, flash_red); end
    end
    bus.match_count = 4'd1;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (flash_red !== 1'b0) begin n_bad++; $display("FAIL flash_at_eval: got %b want 0", flash_red); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (flash_red !== (k < 4)) begin n_bad++; $display("FAIL flash_pulse[%0d]: got %b want %b", k, flash_red, k < 4); end
    end
    n_cmp++;
    if (bit_count !== 4'd4) begin n_bad++; $display("FAIL flash_bits: got %0d want 4", bit_count); end
  endtask

  task automatic test_lockout;
    restart();
    for (int i = 1; i <= 16; i++) begin
      run_bit(1'(i), 4'd0);
      n_cmp++;
      if ({bus.clear_guess, fail_count, bit_count} !== {(i % 8) == 0, 4'(i / 8), 4'(i % 8)}) begin
        n_bad++;
        $display("FAIL attempt_bit[%0d]: got clr=%b fails=%0d bits=%0d want clr=%b fails=%0d bits=%0d",
                 i, bus.clear_guess, fail_count, bit_count, (i % 8) == 0, i / 8, i % 8);
      end
    end
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_before_lock: got %b want 0", overrun); end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if ({locked_out, flash_red, bus.guess_valid} !== 3'b110) begin
        n_bad++; $display("FAIL lockout[%0d]: got %b want 110", k, {locked_out, flash_red, bus.guess_valid});
      end
      if (k == 0) begin sw_bit = 1'b1; sw_req = 1'b1; end
      if (k == 1) sw_req = 1'b0;
      tick();
    end
    n_cmp++;
    if ({locked_out, fail_count, overrun} !== 6'b0_0000_1) begin
      n_bad++; $display("FAIL lock_exit: got %b want 000001", {locked_out, fail_count, overrun});
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.guess_valid !== 1'b0) begin n_bad++; $display("FAIL lock_drop_valid[%0d]: got %b want 0", k, bus.guess_valid); end
      tick();
    end
  endtask

  task automatic test_unlock;
    restart();
    run_bit(1'b1, 4'd1);
    run_bit(1'b1, 4'd8);
    n_cmp++;
    if ({unlocked, flash_red, bit_count} !== 6'b10_0001) begin
      n_bad++; $display("FAIL unlock_state: got %b want 100001", {unlocked, flash_red, bit_count});
    end
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({unlocked, bus.guess_valid} !== 2'b10) begin
        n_bad++; $display("FAIL unlock_drop[%0d]: got %b want 10", k, {unlocked, bus.guess_valid});
      end
      tick();
    end
    relock = 1'b1;
    tick();
    relock = 1'b0;
    n_cmp++;
    if ({bus.clear_guess, unlocked, fail_count, bit_count} !== 10'b10_0000_0000) begin
      n_bad++; $display("FAIL relock: got %b want 1000000000", {bus.clear_guess, unlocked, fail_count, bit_count});
    end
    tick();
    n_cmp++;
    if (bus.clear_guess !== 1'b0) begin n_bad++; $display("FAIL relock_pulse: got %b want 0", bus.clear_guess); end
    run_bit(1'b0, 4'd2);
    n_cmp++;
    if (bit_count !== 4'd1) begin n_bad++; $display("FAIL relock_armed: got %0d want 1", bit_count); end
  endtask

  task automatic test_abort;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    tick();
    n_cmp++;
    if (bus.guess_valid !== 1'b1) begin n_bad++; $display("FAIL abort_shift: got %b want 1", bus.guess_valid); end
    bus.secret_ready = 1'b0;
    tick();
    n_cmp++;
    if (outs !== 16'h0001) begin n_bad++; $display("FAIL secret_drop: got %h want 0001", outs); end
    bus.secret_ready = 1'b1;
    tick();
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 16'h0000) begin n_bad++; $display("FAIL reset_mid_eval: got %h want 0000", outs); end
    bus.secret_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    tick();
    n_cmp++;
    if ({overrun, bus.guess_valid} !== 2'b10) begin
      n_bad++; $display("FAIL idle_drop: got %b want 10", {overrun, bus.guess_valid});
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_latency();
    test_flash();
    test_lockout();
    test_unlock();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
